// File: rtl/dlfloat_mac_sequencer.sv
// Pairs a valid/ready stream of dlfloat words into A/B operands for the MAC,
// waits out the MAC pipeline after the last pair and holds the accumulator result.
module dlfloat_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_valid,
    output logic             acc_clr,
    input  logic [15:0]      mac_c,
    output logic [15:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int DRN_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DRAIN,
        HOLD
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   pair_cnt_q;
    logic [DRN_W-1:0]   drain_q;
    logic [15:0]        a_q;
    logic [15:0]        op_a_q;
    logic [15:0]        op_b_q;
    logic               op_valid_q;
    logic               acc_clr_q;
    logic [15:0]        res_data_q;
    logic               res_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pair_cnt_q  <= '0;
            drain_q     <= '0;
            a_q         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            acc_clr_q   <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // Operands default to zero so the free-running MAC adds nothing.
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            len_q      <= cfg_len;
                            pair_cnt_q <= '0;
                            acc_clr_q  <= 1'b1;
                            state_q    <= LOAD_A;
                        end else begin
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        a_q     <= in_data;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        op_a_q     <= a_q;
                        op_b_q     <= in_data;
                        op_valid_q <= 1'b1;
                        pair_cnt_q <= pair_cnt_q + LEN_W'(1);
                        // Compare before incrementing so len = 2^LEN_W-1 never wraps.
                        if (pair_cnt_q == len_q - LEN_W'(1)) begin
                            drain_q <= DRN_W'(MAC_LAT);
                            state_q <= DRAIN;
                        end else begin
                            state_q <= LOAD_A;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        res_data_q  <= mac_c;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy      = (state_q != IDLE);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign acc_clr   = acc_clr_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// Randomized bench for dlfloat_mac_sequencer: a free-running random mac_c, a
// monitor logging DUT activity, and per-scenario checks against a word-queue model.
module tb_dlfloat_mac_sequencer;

    localparam int LEN_W   = 4;
    localparam int MAC_LAT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [15:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_valid;
    logic             acc_clr;
    logic [15:0]      mac_c = '0;
    logic [15:0]      res_data;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             busy;

    dlfloat_mac_sequencer #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .acc_clr(acc_clr),
        .mac_c(mac_c), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Edge-indexed history of what mac_c showed at each rising edge.
    int          edge_n = 0;
    logic [15:0] mac_hist [0:65535];
    always @(posedge clk) begin
        mac_hist[edge_n[15:0]] <= mac_c;
        edge_n <= edge_n + 1;
    end
    always @(negedge clk) mac_c <= 16'($urandom);

    // Monitor: edge index of an observation = edge_n - 1 at the following negedge.
    int          mon_acc, mon_acc_ready, mon_zero_viol, last_op_edge, res_edge, start_edge;
    bit          res_seen;
    logic [15:0] res_first;
    logic [15:0] obs_q[$];
    always @(negedge clk) begin
        if (acc_clr) begin
            mon_acc++;
            if (in_ready) mon_acc_ready++;
        end
        if (op_valid) begin
            obs_q.push_back(op_a);
            obs_q.push_back(op_b);
            last_op_edge = edge_n - 1;
        end else if (op_a !== 16'h0 || op_b !== 16'h0) begin
            mon_zero_viol++;
        end
        if (res_valid && !res_seen) begin
            res_seen  = 1'b1;
            res_edge  = edge_n - 1;
            res_first = res_data;
        end
    end

    logic [15:0] sent_q[$];
    int          hold_bad, post_valid, post_busy, word_err;
    bit          tmo;

    task automatic fill_random(input int len);
        sent_q.delete();
        for (int i = 0; i < 2 * len; i++) sent_q.push_back(16'($urandom));
    endtask

    task automatic clear_mon();
        obs_q.delete();
        mon_acc = 0; mon_acc_ready = 0; mon_zero_viol = 0;
        res_seen = 1'b0; last_op_edge = -1; res_edge = -1;
    endtask

    // Drives one dot product from sent_q; mode 0 = valid held, 1 = toggling, 2 = random.
    task automatic run_dot(input int len, input int mode, input int rr_delay);
        int idx;
        int guard;
        bit v;
        idx = 0;
        @(negedge clk); #1;
        clear_mon();
        hold_bad = 0; tmo = 1'b0;
        start = 1'b1; cfg_len = LEN_W'(len); start_edge = edge_n;
        @(negedge clk);
        start = 1'b0; cfg_len = LEN_W'($urandom);
        guard = 0;
        while (idx < 2 * len && guard < 1000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard[0] == 1'b0);
            else v = ($urandom_range(0, 1) == 1);
            in_valid = v;
            in_data  = v ? sent_q[idx] : 16'($urandom);
            if (v && in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 1000) tmo = 1'b1;
        #1;
        guard = 0;
        while (!res_seen && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!res_seen) tmo = 1'b1;
        for (int i = 0; i < rr_delay; i++) begin
            res_ready = 1'b0;
            start = (i == 2);
            cfg_len = LEN_W'(1);
            @(negedge clk); #1;
            if (!res_valid || res_data !== res_first || !busy) hold_bad++;
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk); #1;
        post_valid = res_valid;
        post_busy  = busy;
        @(negedge clk); #1;
        res_ready = 1'b0;
        word_err = 0;
        if (obs_q.size() != sent_q.size()) word_err = 1000;
        else for (int i = 0; i < sent_q.size(); i++) if (obs_q[i] !== sent_q[i]) word_err++;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if ({op_a, op_b, res_data, op_valid, acc_clr, in_ready, res_valid, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {op_a, op_b, res_data, op_valid, acc_clr, in_ready, res_valid, busy});
        end
        rst = 1'b1;
        @(negedge clk); #1;
        clear_mon();
        start = 1'b1; cfg_len = LEN_W'(3);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
        @(negedge clk);
        in_data = 16'h2222;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({op_a, op_b, res_data, op_valid, acc_clr, in_ready, res_valid, busy} !== '0) begin
            bad++;
            $display("FAIL reset_midrun_outputs got=%h exp=0",
                     {op_a, op_b, res_data, op_valid, acc_clr, in_ready, res_valid, busy});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        total++;
        if (res_seen || obs_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_result got res_seen=%0d pairs=%0d busy=%b exp 0/0/0",
                     res_seen, obs_q.size() / 2, busy);
        end
        fill_random(1);
        run_dot(1, 0, 0);
        total++;
        if (tmo || word_err != 0 || res_first !== mac_hist[res_edge[15:0]]) begin
            bad++;
            $display("FAIL reset_rerun got tmo=%0d word_err=%0d res=%h exp res=%h",
                     tmo, word_err, res_first, mac_hist[res_edge[15:0]]);
        end
    endtask

    task automatic test_single_pair();
        sent_q.delete();
        sent_q.push_back(16'h3C00);
        sent_q.push_back(16'h3E00);
        run_dot(1, 0, 0);
        total++;
        if (mon_acc != 1 || mon_acc_ready != 1) begin
            bad++;
            $display("FAIL single_acc_clr got pulses=%0d with_ready=%0d exp 1/1", mon_acc, mon_acc_ready);
        end
        total++;
        if (word_err != 0 || obs_q.size() != 2) begin
            bad++;
            $display("FAIL single_operands got err=%0d words=%0d exp 0/2", word_err, obs_q.size());
        end
        total++;
        if (last_op_edge != start_edge + 2) begin
            bad++;
            $display("FAIL single_op_edge got=%0d exp=%0d", last_op_edge, start_edge + 2);
        end
        total++;
        if (res_edge != last_op_edge + MAC_LAT + 1) begin
            bad++;
            $display("FAIL single_latency got=%0d exp=%0d", res_edge, last_op_edge + MAC_LAT + 1);
        end
        total++;
        if (res_first !== mac_hist[res_edge[15:0]]) begin
            bad++;
            $display("FAIL single_res_data got=%h exp=%h", res_first, mac_hist[res_edge[15:0]]);
        end
        total++;
        if (post_valid != 0 || post_busy != 0) begin
            bad++;
            $display("FAIL single_transfer got valid=%0d busy=%0d exp 0/0", post_valid, post_busy);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(4);
        run_dot(4, 1, 0);
        total++;
        if (tmo || obs_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_pulses got tmo=%0d pairs=%0d exp 0/4", tmo, obs_q.size() / 2);
        end
        total++;
        if (word_err != 0) begin
            bad++;
            $display("FAIL b2b_order got err=%0d exp=0", word_err);
        end
        total++;
        if (mon_zero_viol != 0) begin
            bad++;
            $display("FAIL b2b_zero_ops got=%0d exp=0", mon_zero_viol);
        end
        total++;
        if (res_edge != last_op_edge + MAC_LAT + 1 || res_first !== mac_hist[res_edge[15:0]]) begin
            bad++;
            $display("FAIL b2b_result got edge=%0d data=%h exp edge=%0d data=%h",
                     res_edge, res_first, last_op_edge + MAC_LAT + 1, mac_hist[res_edge[15:0]]);
        end
    endtask

    task automatic test_zero_length();
        sent_q.delete();
        run_dot(0, 0, 0);
        total++;
        if (res_edge != start_edge || res_first !== 16'h0000) begin
            bad++;
            $display("FAIL zero_result got edge=%0d data=%h exp edge=%0d data=0000",
                     res_edge, res_first, start_edge);
        end
        total++;
        if (mon_acc != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL zero_no_ops got acc_clr=%0d pairs=%0d exp 0/0", mon_acc, obs_q.size() / 2);
        end
    endtask

    task automatic test_backpressure();
        fill_random(2);
        run_dot(2, 0, 10);
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold_stable got=%0d exp=0", hold_bad);
        end
        total++;
        if (post_valid != 0 || post_busy != 0) begin
            bad++;
            $display("FAIL bp_release got valid=%0d busy=%0d exp 0/0", post_valid, post_busy);
        end
        total++;
        if (word_err != 0 || res_first !== mac_hist[res_edge[15:0]]) begin
            bad++;
            $display("FAIL bp_result got err=%0d data=%h exp 0/%h", word_err, res_first, mac_hist[res_edge[15:0]]);
        end
    endtask

    task automatic test_max_length();
        fill_random(15);
        run_dot(15, 0, 0);
        total++;
        if (tmo || obs_q.size() != 30 || word_err != 0) begin
            bad++;
            $display("FAIL max_pairs got tmo=%0d pairs=%0d err=%0d exp 0/15/0",
                     tmo, obs_q.size() / 2, word_err);
        end
        total++;
        if (res_edge != last_op_edge + MAC_LAT + 1 || res_first !== mac_hist[res_edge[15:0]] || post_busy != 0) begin
            bad++;
            $display("FAIL max_result got edge=%0d data=%h busy=%0d exp edge=%0d data=%h busy=0",
                     res_edge, res_first, post_busy, last_op_edge + MAC_LAT + 1, mac_hist[res_edge[15:0]]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int len;
            len = $urandom_range(1, 15);
            fill_random(len);
            run_dot(len, 2, $urandom_range(0, 3));
            total++;
            if (tmo || word_err != 0 || mon_acc != 1 || mon_zero_viol != 0
                || res_first !== mac_hist[res_edge[15:0]] || res_edge != last_op_edge + MAC_LAT + 1) begin
                bad++;
                $display("FAIL random_run len=%0d got tmo=%0d err=%0d acc=%0d zv=%0d data=%h exp data=%h",
                         len, tmo, word_err, mon_acc, mon_zero_viol, res_first, mac_hist[res_edge[15:0]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_zero_length();
        test_backpressure();
        test_max_length();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlfloat_mac_sequencer.md
# dlfloat_mac_sequencer

Operand sequencer that sits directly upstream of the dlfloat MAC: it accepts a stream of 16-bit dlfloat words over a valid/ready handshake and pairs them into A/B operands. It presents one product pair per accepted pair and zeros otherwise, so the free-running accumulator only sees intended terms. After the last pair of a dot product it waits out the MAC pipeline, captures the accumulator output and holds it on a valid/ready result port.

## Interface
- LEN_W, 8, width of the pair-count configuration
- MAC_LAT, 3, clock edges from op_valid of a pair until its contribution is visible on mac_c
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin a dot product; sampled only in IDLE
- cfg_len  input  LEN_W  number of A/B pairs; sampled with start
- in_data  input  16  dlfloat operand word (A first, then B)
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts in_data this cycle
- op_a  output  16  operand A to MAC
- op_b  output  16  operand B to MAC
- op_valid  output  1  op_a/op_b carry a real pair this cycle
- acc_clr  output  1  one-cycle accumulator clear to MAC
- mac_c  input  16  MAC accumulator output
- res_data  output  16  captured dot-product result
- res_valid  output  1  res_data valid
- res_ready  input  1  consumer accepts result
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_A, LOAD_B, DRAIN, HOLD. All outputs are registered; in_ready and busy are decoded from the state register only, with no combinational path from in_valid.
- IDLE
  - start=1 and cfg_len≠0: latch len, clear pair counter, pulse acc_clr for 1 cycle, go to LOAD_A.
  - start=1 and cfg_len=0: res_data<=0, res_valid<=1, go to HOLD. No acc_clr.
- LOAD_A
  - in_ready=1.
  - Handshake (in_valid&in_ready): hold in_data in an internal A register, go to LOAD_B.
- LOAD_B
  - in_ready=1.
  - Handshake: op_a<=A, op_b<=in_data, op_valid<=1 for exactly 1 cycle, and the pair counter increments.
  - If this was pair len: load drain counter with MAC_LAT, go to DRAIN. Otherwise go to LOAD_A.
- Whenever op_valid=0, op_a=op_b=16'h0000, so the MAC adds a zero product.
- DRAIN
  - in_ready=0.
  - Drain counter decrements once per cycle. On reaching 0: res_data<=mac_c, res_valid<=1, go to HOLD.
- HOLD
  - res_data and res_valid are stable until res_valid&res_ready, then res_valid<=0 and go to IDLE.
  - start is ignored in every non-IDLE state.
- Pair counter is LEN_W bits wide. len=2^LEN_W−1 must complete without wrap.
- No arithmetic is performed on operand data; words pass bit-exact.

## Timing
- Reset values: state IDLE; op_a, op_b, res_data = 0; op_valid, acc_clr, in_ready, res_valid, busy = 0.
- Reset mid-operation aborts immediately; no partial result is produced and the next start is clean.
- acc_clr is high in the cycle after the start edge, coincident with the first in_ready=1.
- Throughput: one pair per 2 cycles with in_valid held high.
- Stalls: in_valid low stretches LOAD_A/LOAD_B indefinitely with op_valid=0.
- Result latency: res_valid rises on the edge MAC_LAT+1 edges after the edge that raised op_valid for the last pair.
- Result capture: res_data is mac_c sampled at that edge.
- res_ready high on the same cycle res_valid rises: transfer completes in that cycle, and the next cycle is IDLE.
- res_ready held high while IDLE has no effect.
- Next start is accepted one cycle after the result transfer.

## Test plan
- Reset: assert rst=0 mid-LOAD_B, release -> all outputs 0, state IDLE, no res_valid, and a subsequent len=1 run works.
- Single pair: len=1, in_data 3C00 then 3E00 with in_valid held -> acc_clr one cycle, one op_valid pulse with op_a=3C00/op_b=3E00, res_valid exactly MAC_LAT+1 cycles later with res_data=mac_c.
- Back-to-back with bubbles: len=4, in_valid toggling every cycle -> exactly 4 op_valid pulses, op_a/op_b=0 between pulses, correct A/B ordering.
- Zero length: start with cfg_len=0 -> res_valid=1, res_data=0000 next cycle, no acc_clr or op_valid.
- Result backpressure: res_ready held low 10 cycles -> res_data stable, start ignored, busy=1; res_ready=1 -> IDLE next cycle.
- Max length: LEN_W=4, len=15 -> exactly 15 pairs consumed, no counter wrap, single result.
